operand_fetch: RTL

- Issue stage directly upstream of the ALU.
- Decodes an R-type instruction word and reads two operands from an internal 32x32 register file.
- Presents Src_1/Src_2/Funct to the ALU through a one-entry valid/ready pipeline register.
- Accepts the ALU Result back through a write-back port, and stalls on read-after-write hazards using a pending-write scoreboard.

---
 rtl/opf_pkg.sv | 23 ++
 rtl/opf_if.sv | 31 +++
 rtl/opf_regfile.sv | 37 +++
 rtl/operand_fetch.sv | 129 ++++++++++++
 4 files changed

// File: rtl/opf_pkg.sv
// Shared definitions for the operand-fetch stage: instruction field slices,
// funct encodings and default sizing.
package opf_pkg;

    localparam int NREG_DEF = 32;
    localparam int DW_DEF   = 32;
    localparam int AW       = 5;

    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam logic [5:0] FUNCT_PASS = 6'b000000;
    localparam logic [5:0] FUNCT_ADD  = 6'b000001;

    typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/opf_if.sv
// Bus bundle for operand_fetch: instruction input handshake, ALU-facing
// output handshake and the write-back port.
// slave  = the operand_fetch stage, master = its environment (decode/ALU).
interface opf_if import opf_pkg::*; #(
    parameter int DW = DW_DEF
) ();

    logic           in_valid;
    logic           in_ready;
    logic [31:0]    instr;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  Src_1;
    logic [DW-1:0]  Src_2;
    logic [5:0]     Funct;
    logic [AW-1:0]  out_rd;
    logic           wb_en;
    logic [AW-1:0]  wb_addr;
    logic [DW-1:0]  wb_data;

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, Src_1, Src_2, Funct, out_rd
    );

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, Src_1, Src_2, Funct, out_rd
    );

endinterface

// File: rtl/opf_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero, whole array cleared by asynchronous reset.
module opf_regfile import opf_pkg::*; #(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] mem [NREG];

    // Write port; r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Read ports force zero for r0 independent of array contents.
    always_comb begin
        rd1 = (ra1 == '0) ? '0 : mem[ra1];
        rd2 = (ra2 == '0) ? '0 : mem[ra2];
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch issue stage: decodes an R-type word, reads rs/rt from the
// register file, tracks in-flight destinations in a pending scoreboard to
// stall read-after-write hazards, and presents operands to the ALU through a
// one-entry valid/ready register.
// Optional build macro OPF_WB_BYPASS_EN: forwards same-cycle write-back data
// into the issuing instruction's operands and lifts the matching hazard.
module operand_fetch import opf_pkg::*; #(
    parameter int NREG = NREG_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic  clk,
    input  logic  rst,
    opf_if.slave  bus
);

    logic [AW-1:0]   rs_p0, rt_p0, rd_p0;
    logic [5:0]      funct_p0;
    logic [DW-1:0]   rf_rd1, rf_rd2;
    logic [DW-1:0]   src1_p0, src2_p0;
    logic            pend_rs, pend_rt;
    logic            hz, in_rdy, issue;
    logic [NREG-1:0] pend_p1, pend_nxt;

    logic            vld_p1;
    logic [DW-1:0]   src1_p1, src2_p1;
    logic [5:0]      funct_p1;
    logic [AW-1:0]   rd_p1;

    logic            unused_instr_bits;

    assign rs_p0    = bus.instr[RS_MSB:RS_LSB];
    assign rt_p0    = bus.instr[RT_MSB:RT_LSB];
    assign rd_p0    = bus.instr[RD_MSB:RD_LSB];
    assign funct_p0 = bus.instr[FUNCT_MSB:FUNCT_LSB];
    assign unused_instr_bits = ^{bus.instr[31:26], bus.instr[10:6]};

    opf_regfile #(.NREG(NREG), .DW(DW)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (rs_p0),
        .ra2 (rt_p0),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (bus.wb_en),
        .wa  (bus.wb_addr),
        .wd  (bus.wb_data)
    );

`ifdef OPF_WB_BYPASS_EN
    logic wb_hit_rs, wb_hit_rt;
    assign wb_hit_rs = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rs_p0);
    assign wb_hit_rt = bus.wb_en && (bus.wb_addr != '0) && (bus.wb_addr == rt_p0);

    // A write-back landing this cycle both supplies the operand and retires its pending mark.
    always_comb begin
        pend_rs = pend_p1[rs_p0] && !wb_hit_rs;
        pend_rt = pend_p1[rt_p0] && !wb_hit_rt;
        src1_p0 = wb_hit_rs ? bus.wb_data : rf_rd1;
        src2_p0 = wb_hit_rt ? bus.wb_data : rf_rd2;
    end
`else
    // Without forwarding a same-cycle write-back still counts as pending; the
    // dependent instruction reads the updated file one cycle later.
    always_comb begin
        pend_rs = pend_p1[rs_p0];
        pend_rt = pend_p1[rt_p0];
        src1_p0 = rf_rd1;
        src2_p0 = rf_rd2;
    end
`endif

    // Hazard and handshake; self-dependency is not a hazard because rd is
    // only marked pending once the instruction actually issues.
    always_comb begin
        hz     = bus.in_valid && (((rs_p0 != '0) && pend_rs) || ((rt_p0 != '0) && pend_rt));
        in_rdy = (!vld_p1 || bus.out_ready) && !hz;
        issue  = bus.in_valid && in_rdy;
    end

    // Scoreboard next state: write-back clears, issue sets afterwards so set
    // wins on a same-index collision; r0 is never pending.
    always_comb begin
        pend_nxt = pend_p1;
        if (bus.wb_en) begin
            pend_nxt[bus.wb_addr] = 1'b0;
        end
        if (issue && (rd_p0 != '0)) begin
            pend_nxt[rd_p0] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_p1 <= '0;
        end else begin
            pend_p1 <= pend_nxt;
        end
    end

    // ---- stage boundary: issue -> ALU output register ----
    // Output register loads on issue, drops valid on drain, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            src1_p1  <= '0;
            src2_p1  <= '0;
            funct_p1 <= '0;
            rd_p1    <= '0;
        end else if (issue) begin
            vld_p1   <= 1'b1;
            src1_p1  <= src1_p0;
            src2_p1  <= src2_p0;
            funct_p1 <= funct_p0;
            rd_p1    <= rd_p0;
        end else if (vld_p1 && bus.out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_p1;
    assign bus.Src_1     = src1_p1;
    assign bus.Src_2     = src2_p1;
    assign bus.Funct     = funct_p1;
    assign bus.out_rd    = rd_p1;

endmodule
